// File: rtl/csr_unit_pkg.sv
// Shared types, CSR addresses, WARL masks and the RMW helper for csr_unit.
package csr_unit_pkg;

  typedef logic [11:0] csr_addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    CsrOpIllegal = 2'b00,
    CsrOpRw      = 2'b01,
    CsrOpRs      = 2'b10,
    CsrOpRc      = 2'b11
  } csr_op_e;

  typedef enum logic [0:0] {
    StIdle,
    StResp
  } csr_state_e;

  // User-level CSR addresses
  localparam csr_addr_t CsrUstatus  = 12'h000;
  localparam csr_addr_t CsrFflags   = 12'h001;
  localparam csr_addr_t CsrFrm      = 12'h002;
  localparam csr_addr_t CsrFcsr     = 12'h003;
  localparam csr_addr_t CsrUie      = 12'h004;
  localparam csr_addr_t CsrUtvec    = 12'h005;
  localparam csr_addr_t CsrUscratch = 12'h040;
  localparam csr_addr_t CsrUepc     = 12'h041;
  localparam csr_addr_t CsrUcause   = 12'h042;
  localparam csr_addr_t CsrUtval    = 12'h043;
  localparam csr_addr_t CsrUip      = 12'h044;
  localparam csr_addr_t CsrCycle    = 12'hC00;
  localparam csr_addr_t CsrTime     = 12'hC01;
  localparam csr_addr_t CsrInstret  = 12'hC02;
  localparam csr_addr_t CsrCycleh   = 12'hC80;
  localparam csr_addr_t CsrTimeh    = 12'hC81;
  localparam csr_addr_t CsrInstreth = 12'hC82;

  // Writable-bit masks
  localparam data_t UstatusMask = 32'h0000_0011;
  localparam data_t UieUipMask  = 32'h0000_0111;
  localparam data_t UtvecMask   = 32'hFFFF_FFFD;
  localparam data_t UepcMask    = 32'hFFFF_FFFE;
  localparam data_t FcsrMask    = 32'h0000_00FF;

  // Bit positions
  localparam int unsigned UstatusUieBit  = 0;
  localparam int unsigned UstatusUpieBit = 4;
  localparam int unsigned FcsrFflagsMsb  = 4;
  localparam int unsigned FcsrFrmLsb     = 5;
  localparam int unsigned FcsrFrmMsb     = 7;

  // Read-modify-write result for a CSR instruction
  function automatic data_t csr_new_value(csr_op_e op, data_t old_val, data_t wdata);
    data_t res;
    unique case (op)
      CsrOpRw: res = wdata;
      CsrOpRs: res = old_val | wdata;
      CsrOpRc: res = old_val & ~wdata;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running 64-bit event counter; wraps to zero after all-ones.
module csr_counter64 (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_inc,
  output logic [63:0] o_count
);

  logic [63:0] count_q;

  // Count one per cycle while i_inc is high
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_inc) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/csr_unit.sv
// User-level CSR responder: RW/RS/RC accesses answered one cycle after accept,
// U-mode trap CSRs, FP control CSRs and the cycle/time/instret counters.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter logic [31:0] RESET_UTVEC = 32'h0000_0000,
  parameter bit          HAS_FP      = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic [1:0]  i_op,
  input  logic [11:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wen,
  output logic        o_ready,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_illegal,
  input  logic        i_instRetired,
  input  logic        i_tick,
  input  logic        i_trap,
  input  logic [31:0] i_trapCause,
  input  logic [31:0] i_trapEpc,
  input  logic [31:0] i_trapTval,
  output logic [31:0] o_utvec,
  output logic [31:0] o_uepc,
  output logic        o_uie
);

  csr_state_e state_q;
  logic       ready_q, ack_q, illegal_q;
  data_t      rdata_q;

  logic       status_uie_q, status_upie_q;
  data_t      uie_csr_q, uip_csr_q, utvec_q, uscratch_q, uepc_q, ucause_q, utval_q;
  logic [4:0] fflags_q;
  logic [2:0] frm_q;

  logic [63:0] cycle_cnt, time_cnt, instret_cnt;

  csr_op_e op;
  data_t   rd_val, new_val;
  logic    known, is_counter, is_fp, illegal, accept, wr_en;

  assign op = csr_op_e'(i_op);

  csr_counter64 u_cycle (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (1'b1),
    .o_count (cycle_cnt)
  );

  csr_counter64 u_time (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (i_tick),
    .o_count (time_cnt)
  );

  csr_counter64 u_instret (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (i_instRetired),
    .o_count (instret_cnt)
  );

  // Address decode: current value and class of the addressed CSR
  always_comb begin
    rd_val     = '0;
    known      = 1'b1;
    is_counter = 1'b0;
    is_fp      = 1'b0;
    case (i_addr)
      CsrUstatus:  rd_val = {27'b0, status_upie_q, 3'b0, status_uie_q};
      CsrUie:      rd_val = uie_csr_q;
      CsrUip:      rd_val = uip_csr_q;
      CsrUtvec:    rd_val = utvec_q;
      CsrUscratch: rd_val = uscratch_q;
      CsrUepc:     rd_val = uepc_q;
      CsrUcause:   rd_val = ucause_q;
      CsrUtval:    rd_val = utval_q;
      CsrFflags:   begin is_fp = 1'b1; rd_val = {27'b0, fflags_q}; end
      CsrFrm:      begin is_fp = 1'b1; rd_val = {29'b0, frm_q}; end
      CsrFcsr:     begin is_fp = 1'b1; rd_val = {24'b0, frm_q, fflags_q}; end
      CsrCycle:    begin is_counter = 1'b1; rd_val = cycle_cnt[31:0]; end
      CsrTime:     begin is_counter = 1'b1; rd_val = time_cnt[31:0]; end
      CsrInstret:  begin is_counter = 1'b1; rd_val = instret_cnt[31:0]; end
      CsrCycleh:   begin is_counter = 1'b1; rd_val = cycle_cnt[63:32]; end
      CsrTimeh:    begin is_counter = 1'b1; rd_val = time_cnt[63:32]; end
      CsrInstreth: begin is_counter = 1'b1; rd_val = instret_cnt[63:32]; end
      default:     known = 1'b0;
    endcase
  end

  // Legality, write enable and RMW result
  always_comb begin
    illegal = !known || (op == CsrOpIllegal) || (is_fp && !HAS_FP) || (is_counter && i_wen);
    accept  = i_req && ready_q;
    wr_en   = accept && !illegal && i_wen;
    new_val = csr_new_value(op, rd_val, i_wdata);
  end

  // CSR state; trap updates come last so they override a same-edge write
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      status_uie_q  <= 1'b0;
      status_upie_q <= 1'b0;
      uie_csr_q     <= '0;
      uip_csr_q     <= '0;
      utvec_q       <= RESET_UTVEC & UtvecMask;
      uscratch_q    <= '0;
      uepc_q        <= '0;
      ucause_q      <= '0;
      utval_q       <= '0;
      fflags_q      <= '0;
      frm_q         <= '0;
    end else begin
      if (wr_en) begin
        case (i_addr)
          CsrUstatus: begin
            status_uie_q  <= new_val[UstatusUieBit];
            status_upie_q <= new_val[UstatusUpieBit];
          end
          CsrUie:      uie_csr_q  <= new_val & UieUipMask;
          CsrUip:      uip_csr_q  <= new_val & UieUipMask;
          CsrUtvec:    utvec_q    <= new_val & UtvecMask;
          CsrUscratch: uscratch_q <= new_val;
          CsrUepc:     uepc_q     <= new_val & UepcMask;
          CsrUcause:   ucause_q   <= new_val;
          CsrUtval:    utval_q    <= new_val;
          CsrFflags:   fflags_q   <= new_val[FcsrFflagsMsb:0];
          CsrFrm:      frm_q      <= new_val[2:0];
          CsrFcsr: begin
            fflags_q <= new_val[FcsrFflagsMsb:0];
            frm_q    <= new_val[FcsrFrmMsb:FcsrFrmLsb];
          end
          default: ;
        endcase
      end
      if (i_trap) begin
        uepc_q        <= i_trapEpc & UepcMask;
        ucause_q      <= i_trapCause;
        utval_q       <= i_trapTval;
        status_upie_q <= status_uie_q;
        status_uie_q  <= 1'b0;
      end
    end
  end

  // Request/response FSM with registered handshake and data outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q   <= StResp;
            ready_q   <= 1'b0;
            ack_q     <= 1'b1;
            rdata_q   <= illegal ? '0 : rd_val;
            illegal_q <= illegal;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready   = ready_q;
  assign o_ack     = ack_q;
  assign o_rdata   = rdata_q;
  assign o_illegal = illegal_q;
  assign o_utvec   = utvec_q;
  assign o_uepc    = uepc_q;
  assign o_uie     = status_uie_q;

endmodule
